// File: rtl/uart_time_rx.sv
// Serial front end of the digital clock: 8N1 receiver plus "C/A hhmm CR" set-command parser.
// Drives BCD digits with one-cycle load strobes and retriggerable indicator LEDs.
`timescale 1ns/1ps
module uart_time_rx #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned LED_HOLD   = 76800
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       Rx,
    output logic       LD1,
    output logic       LD2,
    output logic       LED1,
    output logic       LED2,
    output logic [3:0] Dig0,
    output logic [3:0] Dig1,
    output logic [3:0] Dig2,
    output logic [3:0] Dig3,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned LED_W = $clog2(LED_HOLD + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
    typedef enum logic [2:0] {P_CMD, P_H1, P_H0, P_M1, P_M0, P_END} p_state_t;

    logic             r_rx_meta, r_rxs;
    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             w_byte_valid, w_stop_err;

    p_state_t         r_p_state, w_p_state_nxt;
    logic             r_tgt, w_tgt_nxt;
    logic [3:0]       r_sh3, r_sh2, r_sh1, r_sh0;
    logic [3:0]       w_sh3_nxt, w_sh2_nxt, w_sh1_nxt, w_sh0_nxt;
    logic [3:0]       w_dig3_nxt, w_dig2_nxt, w_dig1_nxt, w_dig0_nxt;
    logic             w_ld1_nxt, w_ld2_nxt, w_ferr_nxt;
    logic             w_is_cmd, w_is_alarm, w_is_digit, w_range_ok;

    logic [LED_W-1:0] r_led1_cnt, r_led2_cnt, w_led1_nxt, w_led2_nxt;

    // Synchronizer and receiver state register
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rx_state <= R_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
        end else begin
            r_rx_meta  <= Rx;
            r_rxs      <= r_rx_meta;
            r_rx_state <= w_rx_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Receiver next state: mid-bit sampling, break wait after a low stop bit
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_byte_valid   = 1'b0;
        w_stop_err     = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rxs) w_rx_state_nxt = R_START;
            end
            R_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt      = '0;
                    w_bit_nxt      = '0;
                    w_rx_state_nxt = r_rxs ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rxs, r_shift[7:1]};
                    if (r_bit == 3'd7) w_rx_state_nxt = R_STOP;
                    else               w_bit_nxt      = r_bit + 3'd1;
                end
            end
            R_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_nxt = '0;
                    if (r_rxs) begin
                        w_byte_valid   = 1'b1;
                        w_rx_state_nxt = R_IDLE;
                    end else begin
                        w_stop_err     = 1'b1;
                        w_rx_state_nxt = R_BREAK;
                    end
                end
            end
            R_BREAK: begin
                w_cnt_nxt = '0;
                if (r_rxs) w_rx_state_nxt = R_IDLE;
            end
            default: w_rx_state_nxt = R_IDLE;
        endcase
    end

    assign w_is_alarm = (r_shift == 8'h41) || (r_shift == 8'h61);
    assign w_is_cmd   = w_is_alarm || (r_shift == 8'h43) || (r_shift == 8'h63);
    assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);
    assign w_range_ok = ((r_sh3 < 4'd2) || ((r_sh3 == 4'd2) && (r_sh2 <= 4'd3))) && (r_sh1 <= 4'd5);

    // Parser, output and LED registers
    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            r_p_state  <= P_CMD;
            r_tgt      <= 1'b0;
            r_sh3      <= '0;
            r_sh2      <= '0;
            r_sh1      <= '0;
            r_sh0      <= '0;
            Dig3       <= '0;
            Dig2       <= '0;
            Dig1       <= '0;
            Dig0       <= '0;
            LD1        <= 1'b0;
            LD2        <= 1'b0;
            frame_err  <= 1'b0;
            r_led1_cnt <= '0;
            r_led2_cnt <= '0;
            LED1       <= 1'b0;
            LED2       <= 1'b0;
        end else begin
            r_p_state  <= w_p_state_nxt;
            r_tgt      <= w_tgt_nxt;
            r_sh3      <= w_sh3_nxt;
            r_sh2      <= w_sh2_nxt;
            r_sh1      <= w_sh1_nxt;
            r_sh0      <= w_sh0_nxt;
            Dig3       <= w_dig3_nxt;
            Dig2       <= w_dig2_nxt;
            Dig1       <= w_dig1_nxt;
            Dig0       <= w_dig0_nxt;
            LD1        <= w_ld1_nxt;
            LD2        <= w_ld2_nxt;
            frame_err  <= w_ferr_nxt;
            r_led1_cnt <= w_led1_nxt;
            r_led2_cnt <= w_led2_nxt;
            LED1       <= (w_led1_nxt != '0);
            LED2       <= (w_led2_nxt != '0);
        end
    end

    // Parser next state: a command letter restarts from any state
    always_comb begin
        w_p_state_nxt = r_p_state;
        w_tgt_nxt     = r_tgt;
        w_sh3_nxt     = r_sh3;
        w_sh2_nxt     = r_sh2;
        w_sh1_nxt     = r_sh1;
        w_sh0_nxt     = r_sh0;
        w_dig3_nxt    = Dig3;
        w_dig2_nxt    = Dig2;
        w_dig1_nxt    = Dig1;
        w_dig0_nxt    = Dig0;
        w_ld1_nxt     = 1'b0;
        w_ld2_nxt     = 1'b0;
        w_ferr_nxt    = w_stop_err;
        if (w_stop_err) begin
            w_p_state_nxt = P_CMD;
        end else if (w_byte_valid) begin
            if (w_is_cmd) begin
                w_p_state_nxt = P_H1;
                w_tgt_nxt     = w_is_alarm;
            end else begin
                case (r_p_state)
                    P_H1, P_H0, P_M1, P_M0: begin
                        if (w_is_digit) begin
                            case (r_p_state)
                                P_H1:    begin w_sh3_nxt = r_shift[3:0]; w_p_state_nxt = P_H0;  end
                                P_H0:    begin w_sh2_nxt = r_shift[3:0]; w_p_state_nxt = P_M1;  end
                                P_M1:    begin w_sh1_nxt = r_shift[3:0]; w_p_state_nxt = P_M0;  end
                                default: begin w_sh0_nxt = r_shift[3:0]; w_p_state_nxt = P_END; end
                            endcase
                        end else begin
                            w_ferr_nxt    = 1'b1;
                            w_p_state_nxt = P_CMD;
                        end
                    end
                    P_END: begin
                        w_p_state_nxt = P_CMD;
                        if ((r_shift == 8'h0D) && w_range_ok) begin
                            w_dig3_nxt = r_sh3;
                            w_dig2_nxt = r_sh2;
                            w_dig1_nxt = r_sh1;
                            w_dig0_nxt = r_sh0;
                            w_ld1_nxt  = !r_tgt;
                            w_ld2_nxt  = r_tgt;
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end
                    default: w_p_state_nxt = P_CMD;
                endcase
            end
        end
    end

    // Retriggerable LED hold timers
    always_comb begin
        w_led1_nxt = r_led1_cnt;
        w_led2_nxt = r_led2_cnt;
        if (w_ld1_nxt)               w_led1_nxt = LED_W'(LED_HOLD);
        else if (r_led1_cnt != '0)   w_led1_nxt = r_led1_cnt - LED_W'(1);
        if (w_ld2_nxt)               w_led2_nxt = LED_W'(LED_HOLD);
        else if (r_led2_cnt != '0)   w_led2_nxt = r_led2_cnt - LED_W'(1);
    end

endmodule

// File: tb/tb_uart_time_rx.sv
// Scoreboard bench for uart_time_rx: expected commits are queued as commands are sent
// and checked by a monitor when LD1/LD2 fire; scenario tasks check the rest inline.
`timescale 1ns/1ps
module tb_uart_time_rx;

    localparam int unsigned OS    = 8;
    localparam int unsigned HOLD  = 1200;
    localparam int          CLK_P = 10;

    logic       clk = 1'b0;
    logic       reset_;
    logic       Rx;
    logic       LD1, LD2, LED1, LED2, frame_err;
    logic [3:0] Dig0, Dig1, Dig2, Dig3;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_ferr   = 0;
    int  n_ld     = 0;
    time last_ld_t = 0;
    time t_byte    = 0;
    logic [16:0] exp_q[$];

    always #(CLK_P/2) clk = ~clk;

    uart_time_rx #(.OVERSAMPLE(OS), .LED_HOLD(HOLD)) dut (
        .clk(clk), .reset_(reset_), .Rx(Rx),
        .LD1(LD1), .LD2(LD2), .LED1(LED1), .LED2(LED2),
        .Dig0(Dig0), .Dig1(Dig1), .Dig2(Dig2), .Dig3(Dig3),
        .frame_err(frame_err)
    );

    // Commit monitor: pops the scoreboard on every load strobe
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset_ === 1'b0) begin
            if (frame_err === 1'b1) n_ferr++;
            if (LD1 === 1'b1 || LD2 === 1'b1) begin
                n_ld++;
                last_ld_t = $time;
                n_checks++;
                if (LD1 === 1'b1 && LD2 === 1'b1) begin
                    n_fail++;
                    $display("FAIL ld_overlap: LD1=%b LD2=%b, required not both high", LD1, LD2);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ld: LD1=%b LD2=%b Dig=%h%h%h%h, required no strobe",
                             LD1, LD2, Dig3, Dig2, Dig1, Dig0);
                end else begin
                    e = exp_q.pop_front();
                    if ({LD2, Dig3, Dig2, Dig1, Dig0} !== e)
                        begin n_fail++; $display("FAIL commit: got alarm=%b dig=%h, required alarm=%b dig=%h",
                                                 LD2, {Dig3, Dig2, Dig1, Dig0}, e[16], e[15:0]); end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        Rx = 1'b0;
        t_byte = $time;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (OS) @(negedge clk);
        end
        Rx = stop;
        repeat (OS) @(negedge clk);
        Rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_ = 1'b1;
        Rx     = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({LD1, LD2, LED1, LED2, frame_err, Dig3, Dig2, Dig1, Dig0} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h, required 0",
                     {LD1, LD2, LED1, LED2, frame_err, Dig3, Dig2, Dig1, Dig0});
        end
        reset_ = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_clock_set;
        int  f0;
        int  lat;
        int  dur;
        f0 = n_ferr;
        exp_q.push_back({1'b0, 16'h1234});
        send_str("C1234\r");
        lat = int'((last_ld_t - t_byte) / CLK_P);
        n_checks++;
        if (lat < 77 || lat > 80) begin
            n_fail++; $display("FAIL ld_latency: got %0d cycles, required 77..80", lat);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL clock_drain: %0d commits missing, required 0", exp_q.size()); exp_q.delete();
        end
        n_checks++;
        if ({LED1, LED2} !== 2'b10) begin
            n_fail++; $display("FAIL led_after_ld1: LED1/LED2=%b%b, required 10", LED1, LED2);
        end
        for (int i = 0; i < int'(HOLD) + 50 && LED1 === 1'b1; i++) @(negedge clk);
        dur = int'(($time - last_ld_t) / CLK_P);
        n_checks++;
        if (dur != int'(HOLD)) begin
            n_fail++; $display("FAIL led1_hold: got %0d cycles, required %0d", dur, HOLD);
        end
        n_checks++;
        if (n_ferr != f0) begin
            n_fail++; $display("FAIL clock_ferr: got %0d pulses, required 0", n_ferr - f0);
        end
    endtask

    task automatic test_alarm_both;
        exp_q.push_back({1'b1, 16'h2359});
        send_str("a2359\r");
        n_checks++;
        if ({LED1, LED2} !== 2'b01) begin
            n_fail++; $display("FAIL led_after_ld2: LED1/LED2=%b%b, required 01", LED1, LED2);
        end
        exp_q.push_back({1'b0, 16'h0000});
        send_str("C0000\r");
        n_checks++;
        if ({LED1, LED2} !== 2'b11) begin
            n_fail++; $display("FAIL led_both: LED1/LED2=%b%b, required 11", LED1, LED2);
        end
        n_checks++;
        if ({Dig3, Dig2, Dig1, Dig0} !== 16'h0000) begin
            n_fail++; $display("FAIL dig_zero: got %h, required 0000", {Dig3, Dig2, Dig1, Dig0});
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL alarm_drain: %0d commits missing, required 0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_restart;
        int f0;
        f0 = n_ferr;
        exp_q.push_back({1'b1, 16'h0745});
        send_str("C12A0745\r");
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL restart_drain: %0d commits missing, required 0", exp_q.size()); exp_q.delete();
        end
        n_checks++;
        if (n_ferr != f0) begin
            n_fail++; $display("FAIL restart_ferr: got %0d pulses, required 0", n_ferr - f0);
        end
    endtask

    task automatic test_range_reject;
        int f0;
        int l0;
        f0 = n_ferr;
        l0 = n_ld;
        send_str("C2400\r");
        n_checks++;
        if (n_ferr != f0 + 1) begin
            n_fail++; $display("FAIL reject_hours: got %0d pulses, required 1", n_ferr - f0);
        end
        send_str("C1260\r");
        n_checks++;
        if (n_ferr != f0 + 2) begin
            n_fail++; $display("FAIL reject_minutes: got %0d pulses, required 2", n_ferr - f0);
        end
        n_checks++;
        if (n_ld != l0 || {Dig3, Dig2, Dig1, Dig0} !== 16'h0745) begin
            n_fail++; $display("FAIL reject_hold: ld=%0d dig=%h, required ld=0 dig=0745",
                               n_ld - l0, {Dig3, Dig2, Dig1, Dig0});
        end
    endtask

    task automatic test_glitch_stop;
        int f0;
        f0 = n_ferr;
        exp_q.push_back({1'b0, 16'h1234});
        send_str("C1");
        repeat (20) @(negedge clk);
        Rx = 1'b0;
        repeat (3) @(negedge clk);
        Rx = 1'b1;
        repeat (20) @(negedge clk);
        send_str("234\r");
        n_checks++;
        if (exp_q.size() != 0 || n_ferr != f0) begin
            n_fail++; $display("FAIL glitch: missing=%0d ferr=%0d, required 0 and 0", exp_q.size(), n_ferr - f0);
            exp_q.delete();
        end
        send_byte(8'h35, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_ferr != f0 + 1) begin
            n_fail++; $display("FAIL stop_low: got %0d pulses, required 1", n_ferr - f0);
        end
        exp_q.push_back({1'b0, 16'h0101});
        send_str("C0101\r");
        n_checks++;
        if (exp_q.size() != 0 || n_ferr != f0 + 1) begin
            n_fail++; $display("FAIL after_stop_err: missing=%0d ferr=%0d, required 0 and 1", exp_q.size(), n_ferr - f0);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] ch;
        ch = 8'h32;
        send_byte(8'h43, 1'b1);
        send_byte(8'h31, 1'b1);
        @(negedge clk);
        Rx = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            Rx = ch[i];
            repeat (OS) @(negedge clk);
        end
        repeat (OS/2) @(negedge clk);
        reset_ = 1'b1;
        #1;
        n_checks++;
        if ({LD1, LD2, LED1, LED2, frame_err, Dig3, Dig2, Dig1, Dig0} !== 21'd0) begin
            n_fail++; $display("FAIL midframe_reset: outputs=%h, required 0",
                               {LD1, LD2, LED1, LED2, frame_err, Dig3, Dig2, Dig1, Dig0});
        end
        repeat (3) @(negedge clk);
        Rx = 1'b1;
        reset_ = 1'b0;
        repeat (20) @(negedge clk);
        exp_q.push_back({1'b0, 16'h0930});
        send_str("C0930\r");
        n_checks++;
        if (exp_q.size() != 0 || {Dig3, Dig2, Dig1, Dig0} !== 16'h0930) begin
            n_fail++; $display("FAIL post_reset_commit: missing=%0d dig=%h, required 0 and 0930",
                               exp_q.size(), {Dig3, Dig2, Dig1, Dig0});
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clock_set();
        test_alarm_both();
        test_restart();
        test_range_reject();
        test_glitch_stop();
        test_reset_midframe();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_time_rx.md
Name: uart_time_rx

Overview:
- Serial front end of the digital clock.
- Receives 8N1 characters on Rx at 9600 baud, using the 76.8 kHz tick as an 8x oversampling clock.
- Parses set commands of the form "C hhmm CR" (set clock) and "A hhmm CR" (set alarm), with no space in the actual frame.
- Presents validated BCD digits with a one-cycle load strobe to the clock and alarm load multiplexers, plus per-target indicator LEDs.

Parameters:
- OVERSAMPLE, 8, clk cycles per bit; must be even and at least 4.
- LED_HOLD, 76800, clk cycles LED1/LED2 stay lit after a commit (1 s at 76.8 kHz).

Ports:
- clk  in  1  76.8 kHz clock.
- reset_  in  1  asynchronous reset, active-high (despite the name).
- Rx  in  1  asynchronous serial input; idles high.
- LD1  out  1  one-cycle strobe: load clock time from Dig0..Dig3.
- LD2  out  1  one-cycle strobe: load alarm time from Dig0..Dig3.
- LED1  out  1  high for LED_HOLD cycles after an LD1 commit.
- LED2  out  1  high for LED_HOLD cycles after an LD2 commit.
- Dig0  out  4  minute units, BCD.
- Dig1  out  4  minute tens, BCD.
- Dig2  out  4  hour units, BCD.
- Dig3  out  4  hour tens, BCD.
- frame_err  out  1  one-cycle pulse on a framing error or a rejected command.

Behaviour:
- Reset (async, active-high): all outputs 0, all FSMs to idle, synchronizer flops set to 1, counters cleared.
- Rx passes through a 2-flop synchronizer. All decisions below use the synchronized value rxs.
- Receiver FSM:
  - R_IDLE: on rxs=0, go to R_START and clear the sample counter.
  - R_START: after OVERSAMPLE/2 cycles, resample. If rxs=1 (glitch), return to R_IDLE. Otherwise go to R_DATA.
  - R_DATA: sample every OVERSAMPLE cycles. 8 bits, LSB first, shifted into a byte register.
  - R_STOP: sample after OVERSAMPLE cycles. If rxs=1, pulse byte_valid (internal, one cycle). If rxs=0, pulse frame_err and reset the parser.
  - In both cases the receiver returns to R_IDLE. If it returns with rxs still low, it waits for rxs=1 before re-arming (break handling).
- Parser FSM (advances only on byte_valid):
  - P_CMD: 'C'/'c' (0x43/0x63) selects target=clock; 'A'/'a' (0x41/0x61) selects target=alarm. Any other byte is ignored silently.
  - P_H1, P_H0, P_M1, P_M0: each expects ASCII '0'..'9' and stores byte-0x30 into a shadow digit.
  - P_END: expects CR (0x0D).
- Restart rule: a 'C'/'A' byte in any state other than P_CMD restarts the sequence with the new target. No frame_err.
- Reject rule: any other non-digit in P_H1..P_M0, or a non-CR byte in P_END, returns to P_CMD with a frame_err pulse.
- Commit on CR:
  - Range check: hours = 10*H1 + H0 <= 23 and M1 <= 5.
  - Pass: in the cycle after byte_valid, Dig3..Dig0 take the shadow values and LD1 (clock) or LD2 (alarm) is high for exactly one cycle, aligned with the new Dig values.
  - Fail: no LD, Dig outputs unchanged, frame_err pulse.
  - Parser returns to P_CMD either way.
- Dig0..Dig3 hold their values between commits. They change only on a commit; shadow registers are internal.
- LED timers:
  - A commit reloads the matching counter to LED_HOLD. The LED is high while the counter is nonzero.
  - Retriggerable: a new commit before expiry reloads the counter.
  - The two timers are independent. LED1 and LED2 may both be high.
- LD1 and LD2 are never high in the same cycle.
- Latency: the LD strobe occurs 2 + 0.5 + 9 bit-times (= OVERSAMPLE*9.5 + 2 cycles) after the falling edge of the CR start bit at the Rx pin, ±1 cycle.
- Reset mid-frame discards any partial byte and partial command. Dig outputs return to 0.

Test Plan:
- Send "C1234\r" at 9600 baud -> Dig3..0 = 1,2,3,4; LD1 high exactly one cycle, LD2 stays 0; LED1 high for 76800 cycles then low.
- Send "a2359\r" -> Dig = 2,3,5,9; one LD2 pulse; LED2 lit. Then send "C0000\r" within 1 s -> both LEDs high simultaneously; Dig = 0,0,0,0.
- Send "C2400\r", then "C1260\r" -> no LD pulse; one frame_err pulse per command; Dig retains the prior value.
- Send "C12A0745\r" -> the 'A' restarts parsing; with the remaining "0745\r", commit to the alarm: LD2 pulses, Dig = 0,7,4,5, no frame_err.
- Drive a 3-cycle low glitch on Rx -> no byte accepted. Send a byte with the stop bit held low -> frame_err pulse; the following valid "C0101\r" commits normally.
- Assert reset_ midway through the data bits of the third character of "C1234\r" -> all outputs 0 immediately; after release, "C0930\r" commits Dig = 0,9,3,0.
